// File: rtl/cmos_capture_gen.sv
// cmos_capture_gen: CMOS sensor capture front end.
//   Registers the raw sensor bus, packs PIX_BYTES beats into one pixel
//   (first beat in the MSBs), tracks pixel column / line index and emits
//   pixels inside the crop window once the enable/skip FSM reaches CAPTURE.
// Ports:
//   pclk, rst                     - pixel clock, synchronous active-high reset
//   en                            - capture enable (acted on at frame boundaries)
//   swap_rb                       - RGB565 R/B swap (PIX_BYTES==2, DATA_W==8 only)
//   cmos_vsync/href/data          - raw sensor interface
//   pix_data, pix_de, pix_vs      - packed pixel stream
//   frame_start, frame_cnt        - captured-frame pulse and counter
//   err_partial                   - sticky: a line ended mid-pixel
module cmos_capture_gen #(
  parameter int DATA_W      = 8,
  parameter int PIX_BYTES   = 2,
  parameter int SKIP_FRAMES = 10,
  parameter int CROP_X0     = 0,
  parameter int CROP_W      = 1280,
  parameter int CROP_Y0     = 0,
  parameter int CROP_H      = 720
) (
  input  logic                        pclk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        swap_rb,
  input  logic                        cmos_vsync,
  input  logic                        cmos_href,
  input  logic [DATA_W-1:0]           cmos_data,
  output logic [DATA_W*PIX_BYTES-1:0] pix_data,
  output logic                        pix_de,
  output logic                        pix_vs,
  output logic                        frame_start,
  output logic [15:0]                 frame_cnt,
  output logic                        err_partial
);

  localparam int          PW        = DATA_W * PIX_BYTES;
  localparam logic [1:0]  PH_LAST   = 2'(PIX_BYTES - 1);
  localparam logic [15:0] SKIP_LAST = 16'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);
  localparam logic        NO_SKIP   = 1'(SKIP_FRAMES == 0);
  localparam logic [11:0] XY_MAX    = 12'hFFF;

  typedef enum logic [1:0] {IDLE, WAIT_VS, SKIP, CAPTURE} state_t;

  state_t             state;
  logic [15:0]        skip_cnt;

  // input register stage and one-cycle history for edge detection
  logic               vs_r, href_r, vs_d, href_d;
  logic [DATA_W-1:0]  data_r;

  logic [1:0]         phase;
  logic [PW-1:0]      acc;
  logic [11:0]        x_cnt, y_cnt;

  // vld_pipe[0]: pixel assembled and accepted; vld_pipe[1]: drives pix_de
  logic [1:0]         vld_pipe;
  logic [PW-1:0]      s1_data, sw_data;

  logic               boundary, href_rise, href_fall, last_beat;
  logic               go_cap, cap_eff, in_crop;
  logic [1:0]         ph_cur;
  logic [11:0]        x_eff, y_eff;
  logic [PW+DATA_W-1:0] wide;
  logic [PW-1:0]      packed_w;
  int                 xi, yi;

  always_comb begin
    boundary  = vs_d & ~vs_r;
    href_rise = href_r & ~href_d;
    href_fall = ~href_r & href_d;
    // a rising href starts a fresh pixel even if the previous line left junk
    ph_cur    = href_rise ? 2'd0 : phase;
    last_beat = href_r && (ph_cur == PH_LAST);
    x_eff     = href_rise ? 12'd0 : x_cnt;
    // boundary is processed before anything on the same cycle
    y_eff     = boundary ? 12'd0 : y_cnt;
    wide      = {acc, data_r};
    packed_w  = wide[PW-1:0];

    // would the FSM be in CAPTURE after this boundary?
    go_cap = 1'b0;
    case (state)
      WAIT_VS: go_cap = en & NO_SKIP;
      SKIP:    go_cap = en & (skip_cnt == SKIP_LAST);
      CAPTURE: go_cap = en;
      default: go_cap = 1'b0;
    endcase
    cap_eff = boundary ? go_cap : (state == CAPTURE);

    xi      = int'({20'd0, x_eff});
    yi      = int'({20'd0, y_eff});
    in_crop = (xi >= CROP_X0) && (xi < CROP_X0 + CROP_W) &&
              (yi >= CROP_Y0) && (yi < CROP_Y0 + CROP_H);
  end

  generate
    if (PIX_BYTES == 2 && DATA_W == 8) begin : g_swap
      assign sw_data = swap_rb ? {s1_data[4:0], s1_data[10:5], s1_data[15:11]} : s1_data;
    end else begin : g_noswap
      assign sw_data = s1_data;
    end
  endgenerate

  assign pix_de = vld_pipe[1];

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= IDLE;
      skip_cnt    <= '0;
      vs_r        <= 1'b0;
      href_r      <= 1'b0;
      data_r      <= '0;
      vs_d        <= 1'b0;
      href_d      <= 1'b0;
      phase       <= '0;
      acc         <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      vld_pipe    <= '0;
      s1_data     <= '0;
      pix_data    <= '0;
      pix_vs      <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      err_partial <= 1'b0;
    end else begin
      vs_r   <= cmos_vsync;
      href_r <= cmos_href;
      data_r <= cmos_data;
      vs_d   <= vs_r;
      href_d <= href_r;

      // beat phase and packing shift register
      if (href_r) begin
        acc   <= packed_w;
        phase <= last_beat ? 2'd0 : ph_cur + 2'd1;
      end else if (href_fall) begin
        phase <= 2'd0;
      end

      // line ended with an incomplete pixel: flag it, the beats are dropped
      if (href_fall && phase != 2'd0)
        err_partial <= 1'b1;

      if (last_beat)
        x_cnt <= (x_eff == XY_MAX) ? x_eff : x_eff + 12'd1;
      else if (href_rise)
        x_cnt <= '0;

      // x_cnt still holds the finished line's pixel count at the fall
      if (boundary)
        y_cnt <= '0;
      else if (href_fall && x_cnt != 12'd0 && y_cnt != XY_MAX)
        y_cnt <= y_cnt + 12'd1;

      vld_pipe <= {vld_pipe[0], last_beat & cap_eff & in_crop};
      if (last_beat)
        s1_data <= packed_w;
      if (vld_pipe[0])
        pix_data <= sw_data;

      pix_vs      <= (state == CAPTURE) & vs_r;
      frame_start <= boundary & go_cap;
      if (boundary & go_cap)
        frame_cnt <= frame_cnt + 16'd1;

      case (state)
        IDLE: if (en) state <= WAIT_VS;
        WAIT_VS: begin
          if (!en) state <= IDLE;
          else if (boundary) begin
            skip_cnt <= '0;
            state    <= NO_SKIP ? CAPTURE : SKIP;
          end
        end
        SKIP: begin
          if (!en) state <= IDLE;
          else if (boundary) begin
            if (skip_cnt == SKIP_LAST) state <= CAPTURE;
            else skip_cnt <= skip_cnt + 16'd1;
          end
        end
        CAPTURE: if (boundary && !en) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
